tracking_multi: RTL and testbench

- Parametrised successor to the single-target green-dot tracker.
- Consumes a raster RGB pixel stream and classifies each pixel against NUM_TARGETS independently configured colour targets.
- Accumulates one bounding box per target per frame; at end of frame, snapshots all boxes into a result bank.
- Drains the result bank one target per beat over a valid/ready interface to the overlay/control logic.

---
 rtl/tracking_multi.sv | 317 +++++++++++++++++++++++++++++++
 tb/tb_tracking_multi.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tracking_multi.sv
// ---------------------------------------------------------------------------
// tracking_multi
//   Multi-target colour tracker. Classifies each pixel of a raster RGB stream
//   against NUM_TARGETS colour targets, accumulates one bounding box per
//   target per frame, snapshots the boxes into a result bank at end of frame
//   and drains the bank one target per beat over a valid/ready interface.
//
// Ports
//   clock, reset        system clock, asynchronous active-low reset
//   in_wr_en            pixel valid (accepted when in_full=0)
//   oR, oG, oB          8-bit pixel colour channels
//   in_full             pixel backpressure (high while committing a frame)
//   target_chan         2 bits per target: 0=R, 1=G, 2=B, 3=disabled
//   out_valid/out_ready result beat handshake
//   out_id              target index of the current beat
//   found               target reached MIN_PIXELS matches this frame
//   center_x/center_y   bounding box centre
//   width/height        bounding box extent
//
// Optional feature, enabled by defining TRACKING_MULTI_SOF_EN:
//   in_sof              start-of-frame marker; the pixel is taken as (0,0) and
//                       the partial frame in progress is discarded
//   sof_resync_cnt      saturating count of in_sof seen away from (0,0)
// ---------------------------------------------------------------------------
module tracking_multi #(
    parameter int WIDTH       = 720,
    parameter int HEIGHT      = 540,
    parameter int NUM_TARGETS = 4,
    parameter int HI_THRESH   = 200,
    parameter int LO_THRESH   = 60,
    parameter int MIN_PIXELS  = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_wr_en,
    input  logic [7:0]               oR,
    input  logic [7:0]               oG,
    input  logic [7:0]               oB,
`ifdef TRACKING_MULTI_SOF_EN
    input  logic                     in_sof,
    output logic [7:0]               sof_resync_cnt,
`endif
    output logic                     in_full,
    input  logic [2*NUM_TARGETS-1:0] target_chan,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2:0]               out_id,
    output logic                     found,
    output logic [11:0]              center_x,
    output logic [11:0]              center_y,
    output logic [11:0]              width,
    output logic [11:0]              height
);

    typedef enum logic {ACCUM, COMMIT} acc_state_t;
    typedef enum logic {IDLE, SEND}    drain_state_t;

    function automatic logic pix_match(input logic [1:0] chan, input logic [7:0] r,
                                       input logic [7:0] g, input logic [7:0] b);
        logic [7:0] key;
        logic [7:0] o1;
        logic [7:0] o2;
        logic       en;
        key = r;
        o1  = g;
        o2  = b;
        en  = 1'b1;
        case (chan)
            2'd0:    begin key = r; o1 = g; o2 = b; end
            2'd1:    begin key = g; o1 = r; o2 = b; end
            2'd2:    begin key = b; o1 = r; o2 = g; end
            default: en = 1'b0;
        endcase
        return en && (key >= 8'(HI_THRESH)) && (o1 <= 8'(LO_THRESH)) && (o2 <= 8'(LO_THRESH));
    endfunction

    function automatic logic [19:0] sat_inc20(input logic [19:0] v);
        return (v == 20'hFFFFF) ? v : v + 20'd1;
    endfunction

    acc_state_t   acc_state, acc_state_nxt;
    drain_state_t drain_state, drain_state_nxt;

    logic        accept;
    logic        sof_acc;
    logic        is_last;
    logic        commit_fire;
    logic        beat_fire;
    logic        last_beat;
    logic [11:0] x_cnt, y_cnt;
    logic [11:0] pos_x, pos_y;

    logic [NUM_TARGETS-1:0] match_p0;
    logic [NUM_TARGETS-1:0] match_p1;
    logic                   vld_p1;
    logic                   sof_p1;
    logic [11:0]            x_p1, y_p1;

    logic [11:0] acc_min_x [NUM_TARGETS];
    logic [11:0] acc_max_x [NUM_TARGETS];
    logic [11:0] acc_min_y [NUM_TARGETS];
    logic [11:0] acc_max_y [NUM_TARGETS];
    logic [19:0] acc_cnt   [NUM_TARGETS];
    logic [11:0] nxt_min_x [NUM_TARGETS];
    logic [11:0] nxt_max_x [NUM_TARGETS];
    logic [11:0] nxt_min_y [NUM_TARGETS];
    logic [11:0] nxt_max_y [NUM_TARGETS];
    logic [19:0] nxt_cnt   [NUM_TARGETS];
    logic [11:0] bank_min_x [NUM_TARGETS];
    logic [11:0] bank_max_x [NUM_TARGETS];
    logic [11:0] bank_min_y [NUM_TARGETS];
    logic [11:0] bank_max_y [NUM_TARGETS];
    logic [19:0] bank_cnt   [NUM_TARGETS];

    logic [11:0] sel_min_x, sel_max_x, sel_min_y, sel_max_y;
    logic [19:0] sel_cnt;
    logic [12:0] sum_x, sum_y;

    assign accept = in_wr_en & ~in_full;

`ifdef TRACKING_MULTI_SOF_EN
    assign sof_acc = accept & in_sof;
`else
    assign sof_acc = 1'b0;
`endif

    // A start-of-frame pixel is forced to the origin regardless of the counters.
    assign pos_x   = sof_acc ? 12'd0 : x_cnt;
    assign pos_y   = sof_acc ? 12'd0 : y_cnt;
    assign is_last = (pos_x == 12'(WIDTH - 1)) && (pos_y == 12'(HEIGHT - 1));

    always_comb begin
        for (int k = 0; k < NUM_TARGETS; k++) begin
            match_p0[k] = pix_match(target_chan[2*k +: 2], oR, oG, oB);
        end
    end

    // ---- stage 0 -> 1: raster position and per-target match ----
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            x_cnt    <= '0;
            y_cnt    <= '0;
            vld_p1   <= 1'b0;
            sof_p1   <= 1'b0;
            match_p1 <= '0;
            x_p1     <= '0;
            y_p1     <= '0;
        end else begin
            vld_p1   <= accept;
            sof_p1   <= sof_acc;
            match_p1 <= accept ? match_p0 : '0;
            x_p1     <= pos_x;
            y_p1     <= pos_y;
            if (accept) begin
                if (pos_x == 12'(WIDTH - 1)) begin
                    x_cnt <= '0;
                    y_cnt <= (pos_y == 12'(HEIGHT - 1)) ? 12'd0 : pos_y + 12'd1;
                end else begin
                    x_cnt <= pos_x + 12'd1;
                    y_cnt <= pos_y;
                end
            end
        end
    end

`ifdef TRACKING_MULTI_SOF_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sof_resync_cnt <= '0;
        end else if (sof_acc && ((x_cnt != 12'd0) || (y_cnt != 12'd0)) &&
                     (sof_resync_cnt != 8'hFF)) begin
            sof_resync_cnt <= sof_resync_cnt + 8'd1;
        end
    end
`endif

    // Next accumulator values including the pixel in stage 1. The snapshot
    // takes these directly, so the final pixel of a frame is included without
    // waiting an extra cycle for the pipeline to drain.
    always_comb begin
        for (int k = 0; k < NUM_TARGETS; k++) begin
            if (sof_p1) begin
                nxt_min_x[k] = '1;
                nxt_max_x[k] = '0;
                nxt_min_y[k] = '1;
                nxt_max_y[k] = '0;
                nxt_cnt[k]   = '0;
            end else begin
                nxt_min_x[k] = acc_min_x[k];
                nxt_max_x[k] = acc_max_x[k];
                nxt_min_y[k] = acc_min_y[k];
                nxt_max_y[k] = acc_max_y[k];
                nxt_cnt[k]   = acc_cnt[k];
            end
            if (vld_p1 && match_p1[k]) begin
                if (x_p1 < nxt_min_x[k]) nxt_min_x[k] = x_p1;
                if (x_p1 > nxt_max_x[k]) nxt_max_x[k] = x_p1;
                if (y_p1 < nxt_min_y[k]) nxt_min_y[k] = y_p1;
                if (y_p1 > nxt_max_y[k]) nxt_max_y[k] = y_p1;
                nxt_cnt[k] = sat_inc20(nxt_cnt[k]);
            end
        end
    end

    // ---- stage 1 -> 2: accumulator update / clear on commit ----
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NUM_TARGETS; k++) begin
                acc_min_x[k] <= '1;
                acc_max_x[k] <= '0;
                acc_min_y[k] <= '1;
                acc_max_y[k] <= '0;
                acc_cnt[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_TARGETS; k++) begin
                if (commit_fire) begin
                    acc_min_x[k] <= '1;
                    acc_max_x[k] <= '0;
                    acc_min_y[k] <= '1;
                    acc_max_y[k] <= '0;
                    acc_cnt[k]   <= '0;
                end else begin
                    acc_min_x[k] <= nxt_min_x[k];
                    acc_max_x[k] <= nxt_max_x[k];
                    acc_min_y[k] <= nxt_min_y[k];
                    acc_max_y[k] <= nxt_max_y[k];
                    acc_cnt[k]   <= nxt_cnt[k];
                end
            end
        end
    end

    // Bank contents are only observed while draining, so they carry no reset.
    always_ff @(posedge clock) begin
        if (commit_fire) begin
            for (int k = 0; k < NUM_TARGETS; k++) begin
                bank_min_x[k] <= nxt_min_x[k];
                bank_max_x[k] <= nxt_max_x[k];
                bank_min_y[k] <= nxt_min_y[k];
                bank_max_y[k] <= nxt_max_y[k];
                bank_cnt[k]   <= nxt_cnt[k];
            end
        end
    end

    // Bank is full exactly while the drain FSM is sending.
    assign commit_fire = (acc_state == COMMIT) && (drain_state == IDLE);
    assign in_full     = (acc_state == COMMIT);
    assign out_valid   = (drain_state == SEND);
    assign beat_fire   = out_valid & out_ready;
    assign last_beat   = (out_id == 3'(NUM_TARGETS - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc_state   <= ACCUM;
            drain_state <= IDLE;
            out_id      <= '0;
        end else begin
            acc_state   <= acc_state_nxt;
            drain_state <= drain_state_nxt;
            if (beat_fire) begin
                out_id <= last_beat ? 3'd0 : out_id + 3'd1;
            end
        end
    end

    always_comb begin
        acc_state_nxt = acc_state;
        case (acc_state)
            ACCUM:   if (accept && is_last) acc_state_nxt = COMMIT;
            COMMIT:  if (commit_fire) acc_state_nxt = ACCUM;
            default: acc_state_nxt = ACCUM;
        endcase
    end

    always_comb begin
        drain_state_nxt = drain_state;
        case (drain_state)
            IDLE:    if (commit_fire) drain_state_nxt = SEND;
            SEND:    if (beat_fire && last_beat) drain_state_nxt = IDLE;
            default: drain_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        sel_min_x = '0;
        sel_max_x = '0;
        sel_min_y = '0;
        sel_max_y = '0;
        sel_cnt   = '0;
        for (int k = 0; k < NUM_TARGETS; k++) begin
            if (out_id == 3'(k)) begin
                sel_min_x = bank_min_x[k];
                sel_max_x = bank_max_x[k];
                sel_min_y = bank_min_y[k];
                sel_max_y = bank_max_y[k];
                sel_cnt   = bank_cnt[k];
            end
        end
        sum_x    = {1'b0, sel_min_x} + {1'b0, sel_max_x};
        sum_y    = {1'b0, sel_min_y} + {1'b0, sel_max_y};
        found    = 1'b0;
        center_x = '0;
        center_y = '0;
        width    = '0;
        height   = '0;
        if ((drain_state == SEND) && (sel_cnt >= 20'(MIN_PIXELS))) begin
            found    = 1'b1;
            center_x = sum_x[12:1];
            center_y = sum_y[12:1];
            width    = sel_max_x - sel_min_x + 12'd1;
            height   = sel_max_y - sel_min_y + 12'd1;
        end
    end

endmodule

// File: tb/tb_tracking_multi.sv
// ---------------------------------------------------------------------------
// tb_tracking_multi
//   Scoreboard bench for tracking_multi on a 16x8 raster with two targets
//   (target 0 keyed on red, target 1 keyed on green). Expected beats are
//   queued as frames are issued; a monitor pops and compares each accepted
//   result beat. Build with TRACKING_MULTI_SOF_EN to add the in_sof scenario.
// ---------------------------------------------------------------------------
module tb_tracking_multi;

    localparam int TW = 16;
    localparam int TH = 8;
    localparam int NT = 2;
    localparam int MP = 2;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          in_wr_en = 1'b0;
    logic [7:0]    oR = '0;
    logic [7:0]    oG = '0;
    logic [7:0]    oB = '0;
    logic          in_full;
    logic [2*NT-1:0] target_chan = 4'b01_00;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [2:0]    out_id;
    logic          found;
    logic [11:0]   center_x, center_y, width, height;
`ifdef TRACKING_MULTI_SOF_EN
    logic          in_sof = 1'b0;
    logic [7:0]    sof_resync_cnt;
`endif

    always #5 clock = ~clock;

    tracking_multi #(
        .WIDTH(TW), .HEIGHT(TH), .NUM_TARGETS(NT),
        .HI_THRESH(200), .LO_THRESH(60), .MIN_PIXELS(MP)
    ) dut (
        .clock(clock),
        .reset(reset),
        .in_wr_en(in_wr_en),
        .oR(oR),
        .oG(oG),
        .oB(oB),
`ifdef TRACKING_MULTI_SOF_EN
        .in_sof(in_sof),
        .sof_resync_cnt(sof_resync_cnt),
`endif
        .in_full(in_full),
        .target_chan(target_chan),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_id(out_id),
        .found(found),
        .center_x(center_x),
        .center_y(center_y),
        .width(width),
        .height(height)
    );

    typedef struct {
        int id;
        int fnd;
        int cx;
        int cy;
        int w;
        int h;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Target 0 (red) never sees a red pixel, so its beat is always empty.
    task automatic push_frame(input int fnd, input int cx, input int cy, input int w, input int h);
        sb.push_back('{0, 0, 0, 0, 0, 0});
        sb.push_back('{1, fnd, cx, cy, w, h});
    endtask

    always @(negedge clock) begin
        if (reset && out_valid && out_ready) begin
            exp_t e;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat actual_id=%0d expected=no_beat", out_id);
            end else begin
                e = sb.pop_front();
                chk("beat_id",       int'(out_id),   e.id);
                chk("beat_found",    int'(found),    e.fnd);
                chk("beat_center_x", int'(center_x), e.cx);
                chk("beat_center_y", int'(center_y), e.cy);
                chk("beat_width",    int'(width),    e.w);
                chk("beat_height",   int'(height),   e.h);
            end
        end
    end

    function automatic bit is_green(input int kind, input int x, input int y);
        case (kind)
            0:       return (x >= 5) && (x <= 7) && (y >= 2) && (y <= 4);
            1:       return (x <= 1) && (y == 0);
            2:       return (x == 3) && (y == 3);
            3:       return (x >= 14) && (y >= 6);
            default: return 1'b0;
        endcase
    endfunction

    task automatic send_px(input bit g);
        int guard;
        guard    = 0;
        in_wr_en = 1'b1;
        oR       = 8'd0;
        oG       = g ? 8'd255 : 8'd0;
        oB       = 8'd0;
        while (in_full && guard < 1000) begin
            @(posedge clock); #1;
            guard++;
        end
        if (in_full) begin
            checks++;
            errors++;
            $display("FAIL pixel_accept_timeout actual_in_full=1 expected=0");
        end
        @(posedge clock); #1;
        in_wr_en = 1'b0;
        oG       = 8'd0;
    endtask

    task automatic send_frame(input int kind);
        for (int y = 0; y < TH; y++)
            for (int x = 0; x < TW; x++)
                send_px(is_green(kind, x, y));
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while ((sb.size() != 0 || out_valid) && guard < 2000) begin
            @(posedge clock); #1;
            guard++;
        end
        checks++;
        if (sb.size() != 0 || out_valid) begin
            errors++;
            $display("FAIL drain_timeout actual_pending=%0d expected=0", sb.size());
        end
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int guard;

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        chk("rst_in_full",   int'(in_full),   0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_id",    int'(out_id),    0);
        chk("rst_found",     int'(found),     0);
        chk("rst_center_x",  int'(center_x),  0);
        chk("rst_width",     int'(width),     0);
        reset = 1'b1;
        @(posedge clock); #1;

        // 3x3 green block, consumer always ready; commit and first-beat timing
        out_ready = 1'b1;
        push_frame(1, 6, 3, 3, 3);
        send_frame(0);
        chk("commit_in_full", int'(in_full), 1);
        @(posedge clock); #1;
        chk("commit_one_cycle", int'(in_full),   0);
        chk("first_beat_valid", int'(out_valid), 1);
        wait_idle();

        // Same frame with a 40-cycle stall on the first beat
        out_ready = 1'b0;
        push_frame(1, 6, 3, 3, 3);
        send_frame(0);
        guard = 0;
        while (!out_valid && guard < 20) begin
            @(posedge clock); #1;
            guard++;
        end
        for (int i = 0; i < 40; i++) begin
            chk("stall_valid", int'(out_valid), 1);
            chk("stall_id",    int'(out_id),    0);
            chk("stall_found", int'(found),     0);
            chk("stall_width", int'(width),     0);
            @(posedge clock); #1;
        end
        out_ready = 1'b1;
        wait_idle();

        // Back-to-back frames, second frame's commit held by the stalled drain
        out_ready = 1'b0;
        push_frame(1, 6, 3, 3, 3);
        push_frame(1, 0, 0, 2, 1);
        send_frame(0);
        send_frame(1);
        for (int i = 0; i < 10; i++) begin
            chk("hold_in_full", int'(in_full),   1);
            chk("hold_valid",   int'(out_valid), 1);
            chk("hold_id",      int'(out_id),    0);
            @(posedge clock); #1;
        end
        out_ready = 1'b1;
        wait_idle();

        // Single matched pixel stays below the reporting threshold
        push_frame(0, 0, 0, 0, 0);
        send_frame(2);
        wait_idle();

        // Four pixels in the bottom-right corner, including the last pixel
        push_frame(1, 14, 6, 2, 2);
        send_frame(3);
        wait_idle();

        // Asynchronous reset mid-frame with a stalled drain pending
        out_ready = 1'b0;
        push_frame(1, 6, 3, 3, 3);
        send_frame(0);
        for (int i = 0; i < 50; i++)
            send_px(is_green(0, i % TW, i / TW));
        chk("pre_reset_valid", int'(out_valid), 1);
        #3;
        reset = 1'b0;
        sb.delete();
        #1;
        chk("async_rst_valid",   int'(out_valid), 0);
        chk("async_rst_in_full", int'(in_full),   0);
        chk("async_rst_id",      int'(out_id),    0);
        repeat (2) @(posedge clock);
        #1;
        reset     = 1'b1;
        out_ready = 1'b1;
        push_frame(1, 6, 3, 3, 3);
        send_frame(0);
        wait_idle();

`ifdef TRACKING_MULTI_SOF_EN
        // Start-of-frame marker on pixel 20; earlier green pixels are discarded
        push_frame(1, 0, 0, 2, 1);
        for (int i = 0; i < 20; i++)
            send_px((i == 5) || (i == 19));
        in_sof = 1'b1;
        send_px(1'b1);
        in_sof = 1'b0;
        for (int i = 1; i < TW * TH; i++)
            send_px(is_green(1, i % TW, i / TW));
        wait_idle();
        chk("sof_resync_cnt", int'(sof_resync_cnt), 1);
`endif

        chk("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
